// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the state encoding, default widths and the PC/counter arithmetic.
package pc_seq_pkg;

   localparam int PC_W   = 12;
   localparam int LUT_AW = 6;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pcs_state_t;

   // Taken branches add the signed LUT offset; the add wraps modulo 2**PC_W.
   function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                               input logic [PC_W-1:0] off,
                                               input logic            taken);
      logic [PC_W-1:0] one;
      one = {{(PC_W-1){1'b0}}, 1'b1};
      return taken ? (pc + off) : (pc + one);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : (c + 1'b1);
   endfunction

endpackage

// File: rtl/pc_seq_start_det.sv
// Registers Start and produces a one-cycle pulse on its rising edge.
// The register clears on reset, so a level already high at release reads as an edge.
module pc_seq_start_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   output logic start_pulse_o
);

   logic start_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) start_q <= 1'b0;
      else       start_q <= start_i;
   end

   assign start_pulse_o = start_i & ~start_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, the IDLE/RUN/HALT protocol and the
// retired-instruction counter, and steers taken branches through the external offset LUT.
module pc_sequencer #(
   parameter int D      = 12,
   parameter int LUT_AW = 6
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [D-1:0]      start_addr,
   input  logic              stall,
   input  logic              branch_en,
   input  logic              branch_taken,
   input  logic              halt_instr,
   input  logic [LUT_AW-1:0] lut_idx,
   output logic [LUT_AW-1:0] lut_addr,
   input  logic [D-1:0]      lut_target,
   output logic [D-1:0]      prog_ctr,
   output logic              fetch_valid,
   output logic              Done,
   output logic              fault,
   output logic [15:0]       instr_count,
   output logic [1:0]        dbg_state_o
);

   import pc_seq_pkg::*;

   pcs_state_t  state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        start_pulse;
   logic        br_taken;

   pc_seq_start_det u_start_det (
      .clk_i         (Clk),
      .rst_i         (Reset),
      .start_i       (Start),
      .start_pulse_o (start_pulse)
   );

   assign br_taken = branch_en & branch_taken;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      case (state_q)
         IDLE, HALT: begin
            if (start_pulse) begin
               pc_d    = start_addr;
               cnt_d   = '0;
               fault_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Priority: stall, halt marker, zero-offset fault, branch/sequential advance.
            if (stall) begin
               state_d = RUN;
            end else if (halt_instr) begin
               cnt_d   = sat_inc(cnt_q);
               state_d = HALT;
            end else if (br_taken && (lut_target == '0)) begin
               fault_d = 1'b1;
               state_d = HALT;
            end else begin
               pc_d  = next_pc(pc_q, lut_target, br_taken);
               cnt_d = sat_inc(cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // fetch_valid marks every cycle prog_ctr addresses a live instruction; there is no back-pressure.
   assign lut_addr    = lut_idx;
   assign prog_ctr    = pc_q;
   assign fetch_valid = (state_q == RUN);
   assign Done        = (state_q == HALT);
   assign fault       = fault_q;
   assign instr_count = cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected snapshots are queued as each step is
// driven and popped and compared one cycle later, after the deciding edge.
module tb_pc_sequencer;

  localparam int W = 33;  // {state[1:0], pc[11:0], done, fvalid, fault, cnt[15:0]}

  logic        Clk = 1'b0;
  logic        Reset, Start, stall, branch_en, branch_taken, halt_instr;
  logic [11:0] start_addr, lut_target, prog_ctr;
  logic [5:0]  lut_idx, lut_addr;
  logic        fetch_valid, Done, fault;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .start_addr   (start_addr),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .halt_instr   (halt_instr),
    .lut_idx      (lut_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .prog_ctr     (prog_ctr),
    .fetch_valid  (fetch_valid),
    .Done         (Done),
    .fault        (fault),
    .instr_count  (instr_count),
    .dbg_state_o  (dbg_state)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected post-edge snapshot, take one edge, then pop and compare.
  task automatic step(input string tag, input logic [1:0] st, input logic [11:0] pc,
                      input logic done, input logic fv, input logic flt, input logic [15:0] cnt);
    logic [W-1:0] e;
    lut_idx = 6'($urandom_range(0, 63));
    exp_q.push_back({st, pc, done, fv, flt, cnt});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".state"}, 32'(dbg_state),   32'(e[32:31]));
    chk({tag, ".pc"},    32'(prog_ctr),    32'(e[30:19]));
    chk({tag, ".done"},  32'(Done),        32'(e[18]));
    chk({tag, ".fv"},    32'(fetch_valid), 32'(e[17]));
    chk({tag, ".fault"}, 32'(fault),       32'(e[16]));
    chk({tag, ".cnt"},   32'(instr_count), 32'(e[15:0]));
    chk({tag, ".lut"},   32'(lut_addr),    32'(lut_idx));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; start_addr = '0; stall = 1'b0;
    branch_en = 1'b0; branch_taken = 1'b0; halt_instr = 1'b0;
    lut_target = '0; lut_idx = '0;

    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) step("reset", 2'd0, 12'h000, 0, 0, 0, 16'd0);

    // 2: start at 0x020, five plain instructions, then a stall
    Reset = 1'b0; Start = 1'b1; start_addr = 12'h020;
    step("start", 2'd1, 12'h020, 0, 1, 0, 16'd0);
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) step("seq", 2'd1, 12'(12'h020 + i), 0, 1, 0, 16'(i));
    stall = 1'b1;
    step("stall", 2'd1, 12'h025, 0, 1, 0, 16'd5);
    stall = 1'b0;

    // 3: branch to 0x0A0, taken -143 -> 0x011, back to 0x0A0, not-taken -> 0x0A1
    branch_en = 1'b1; branch_taken = 1'b1;
    lut_target = 12'h07B; step("br_fwd",   2'd1, 12'h0A0, 0, 1, 0, 16'd6);
    lut_target = 12'hF71; step("br_neg",   2'd1, 12'h011, 0, 1, 0, 16'd7);
    lut_target = 12'h08F; step("br_back",  2'd1, 12'h0A0, 0, 1, 0, 16'd8);
    branch_taken = 1'b0;
    lut_target = 12'hF71; step("br_ntkn",  2'd1, 12'h0A1, 0, 1, 0, 16'd9);

    // 4: wrap 0xFFF -> 0x000; 0x005 - 17 -> 0xFF4
    branch_taken = 1'b1;
    lut_target = 12'hF5E; step("to_fff",   2'd1, 12'hFFF, 0, 1, 0, 16'd10);
    branch_en = 1'b0; branch_taken = 1'b0;
    step("wrap", 2'd1, 12'h000, 0, 1, 0, 16'd11);
    branch_en = 1'b1; branch_taken = 1'b1;
    lut_target = 12'h005; step("to_005",   2'd1, 12'h005, 0, 1, 0, 16'd12);
    lut_target = 12'hFEF; step("br_m17",   2'd1, 12'hFF4, 0, 1, 0, 16'd13);

    // 5: zero-offset taken branch faults; held Start must not restart
    lut_target = 12'h000; Start = 1'b1;
    step("fault", 2'd2, 12'hFF4, 1, 0, 1, 16'd13);
    branch_en = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) step("held", 2'd2, 12'hFF4, 1, 0, 1, 16'd13);
    Start = 1'b0;
    step("drop", 2'd2, 12'hFF4, 1, 0, 1, 16'd13);
    Start = 1'b1; start_addr = 12'h300;
    step("restart", 2'd1, 12'h300, 0, 1, 0, 16'd0);

    // 6: Start toggling in RUN is ignored; halt marker is the 7th instruction
    Start = 1'b0;
    step("run1", 2'd1, 12'h301, 0, 1, 0, 16'd1);
    Start = 1'b1; start_addr = 12'h777;
    step("run_start", 2'd1, 12'h302, 0, 1, 0, 16'd2);
    Start = 1'b0;
    for (int i = 3; i <= 6; i++) step("run", 2'd1, 12'(12'h300 + i), 0, 1, 0, 16'(i));
    halt_instr = 1'b1;
    step("halt", 2'd2, 12'h306, 1, 0, 0, 16'd7);
    halt_instr = 1'b0;

    // reset mid-RUN, then Start high out of reset counts as an edge
    Start = 1'b1; start_addr = 12'h100;
    step("rerun", 2'd1, 12'h100, 0, 1, 0, 16'd0);
    Start = 1'b0;
    step("rerun1", 2'd1, 12'h101, 0, 1, 0, 16'd1);
    Reset = 1'b1;
    step("mid_rst", 2'd0, 12'h000, 0, 0, 0, 16'd0);
    Start = 1'b1; start_addr = 12'h0AB;
    step("rst_start", 2'd0, 12'h000, 0, 0, 0, 16'd0);
    Reset = 1'b0;
    step("rel_start", 2'd1, 12'h0AB, 0, 1, 0, 16'd0);
    Start = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
